imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter IMEM_WORDS, default 16384, meaning: instruction memory depth in 32-bit words, word address width 14.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 fetch_req  input  1  core requests an instruction this cycle.
REQ-005 fetch_addr  input  14  word address from the core (PC[15:2]).
REQ-006 fetch_instr  output  32  instruction word returned to the core.
REQ-007 fetch_valid  output  1  fetch_instr is valid this cycle.
REQ-008 cpu_hold  output  1  core shall freeze its PC while high.
REQ-009 cpu_restart  output  1  one-cycle pulse; core reloads PC to 0.
REQ-010 load_start  input  1  one-cycle pulse requesting program download.
REQ-011 load_byte  input  8  download byte from UART receiver.
REQ-012 load_byte_valid  input  1  load_byte valid this cycle (at most one byte per cycle).
REQ-013 load_done  output  1  one-cycle pulse at download completion.
REQ-014 mem_addr  output  14  instruction RAM word address.
REQ-015 mem_din  output  32  instruction RAM write data.
REQ-016 mem_we  output  1  instruction RAM write enable.
REQ-017 mem_dout  input  32  instruction RAM read data, 1-cycle read latency.

Function
REQ-018 States: RUN, LOAD_LEN, LOAD_DATA, DONE; encoding 2 bits.
REQ-019 RUN: mem_addr=fetch_addr, mem_we=0, cpu_hold=0; fetch_valid = fetch_req delayed one cycle; fetch_instr = mem_dout.
REQ-020 RUN + load_start -> LOAD_LEN next cycle; cpu_hold=1 from that cycle; fetch_valid=0 in every state except RUN.
REQ-021 load_start outside RUN is ignored.
REQ-022 LOAD_LEN: capture two bytes, little-endian, into 16-bit word count LEN; after second byte: LEN==0 -> DONE, else -> LOAD_DATA with word counter WC=0.
REQ-023 LOAD_DATA: pack four bytes little-endian (first byte -> bits 7:0); byte count wraps 3->0.
REQ-024 On the fourth byte, the next cycle drives mem_we=1, mem_addr=WC[13:0], mem_din=packed word for exactly one cycle; WC increments; a byte arriving in that same cycle is captured as byte 0 of the next word (no byte loss).
REQ-025 Words with WC >= IMEM_WORDS are consumed but not written (mem_we stays 0).
REQ-026 When WC reaches LEN after a write -> DONE.
REQ-027 DONE lasts one cycle: load_done=1, cpu_restart=1, cpu_hold=1; then RUN.
REQ-028 In LOAD_* states, mem_addr=WC[13:0] when mem_we=0.
REQ-029 Bytes with load_byte_valid=0 are ignored; no timeout.

Reset
REQ-030 rst=1 at a clock edge -> state RUN, LEN=0, WC=0, byte count 0, packed word 0.
REQ-031 Reset values: fetch_valid=0, fetch_instr=mem_dout passthrough, cpu_hold=0, cpu_restart=0, load_done=0, mem_we=0, mem_din=0.
REQ-032 Reset mid-download aborts it: no further mem_we, no load_done, no cpu_restart pulse.

Structure
REQ-033 Shared package holds state encoding, IMEM addr width 14, LEN width 16, BYTES_PER_WORD=4.
REQ-034 One sub-module byte_packer (4x8 -> 32 assembler with byte counter, clear input) is natural; FSM and counters stay in imem_arbiter.

Verification
REQ-035 RUN: fetch_req=1, fetch_addr=0x0005, mem_dout=0x00500093 -> fetch_valid=1, fetch_instr=0x00500093 one cycle later.
REQ-036 load_start, bytes 02 00 13 00 00 00 93 00 50 00 -> writes 0x00000013 @0 and 0x00500093 @1, then load_done and cpu_restart pulse once, cpu_hold low after DONE.
REQ-037 load_start, bytes 00 00 -> DONE directly, no mem_we, load_done pulse.
REQ-038 Back-to-back bytes every cycle for LEN=3 -> exactly three mem_we pulses, addresses 0,1,2, no byte lost.
REQ-039 rst asserted after 6 of 10 download bytes -> RUN next cycle, no further mem_we, no load_done; new load_start restarts at WC=0.
REQ-040 load_start pulsed during LOAD_DATA -> ignored, write sequence unchanged.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// rtl/imem_arbiter_pkg.sv - shared types and sizes for the instruction memory arbiter
//
// Holds the arbiter state encoding, the instruction RAM word address width,
// the download length width and the byte packing geometry.

package imem_arbiter_pkg;

  localparam int IMEM_AW        = 14;
  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_LEN  = 2'd1,
    ST_LOAD_DATA = 2'd2,
    ST_DONE      = 2'd3
  } arb_state_t;

endpackage

// File: rtl/imem_arbiter_byte_packer.sv
// rtl/imem_arbiter_byte_packer.sv - assembles download bytes into little-endian instruction words
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : synchronous clear of byte count and packed word
//   byte_data    : incoming byte
//   byte_valid   : byte_data is valid this cycle
//   word         : packed word (first byte of a word lands in bits 7:0)
//   word_done    : the byte accepted this cycle completes a word

module imem_arbiter_byte_packer
  import imem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  logic [BCNT_W-1:0] cnt_q;
  logic [WORD_W-1:0] word_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (byte_valid) begin
      word_q[{cnt_q, 3'b000} +: 8] <= byte_data;
      // Count wraps naturally from the last byte back to byte 0.
      cnt_q <= cnt_q + BCNT_W'(1);
    end
  end

  assign word      = word_q;
  assign word_done = byte_valid && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - instruction RAM arbiter between core fetch and UART program download
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   fetch_req/fetch_addr     : core fetch request and word address
//   fetch_instr/fetch_valid  : returned instruction, valid one cycle after request
//   cpu_hold                 : core freezes its PC while high
//   cpu_restart              : one-cycle pulse, core reloads PC to 0
//   load_start               : one-cycle pulse requesting a download
//   load_byte/load_byte_valid: download byte stream, at most one byte per cycle
//   load_done                : one-cycle pulse when a download completes
//   mem_addr/mem_din/mem_we  : instruction RAM address, write data, write enable
//   mem_dout                 : instruction RAM read data, one-cycle latency
//
// Download format: 16-bit little-endian word count, then that many
// little-endian 32-bit words. Words beyond IMEM_WORDS are consumed but
// not written.

module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int IMEM_WORDS = 16384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [IMEM_AW-1:0] fetch_addr,
  output logic [31:0]        fetch_instr,
  output logic               fetch_valid,
  output logic               cpu_hold,
  output logic               cpu_restart,
  input  logic               load_start,
  input  logic [7:0]         load_byte,
  input  logic               load_byte_valid,
  output logic               load_done,
  output logic [IMEM_AW-1:0] mem_addr,
  output logic [31:0]        mem_din,
  output logic               mem_we,
  input  logic [31:0]        mem_dout
);

  arb_state_t        state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  wc_q;
  logic              len_hi_q;
  logic              fetch_pend_q;
  logic              word_pend_q;

  logic [WORD_W-1:0] packed_word;
  logic              packed_done;
  logic              pk_valid;
  logic              pk_clear;
  logic [LEN_W-1:0]  len_full;
  logic              wc_last;
  logic              wc_in_range;

  // Packer only sees bytes while streaming data words; it is held clear
  // otherwise so every download starts at byte 0 with a zero word.
  assign pk_valid = load_byte_valid && (state_q == ST_LOAD_DATA);
  assign pk_clear = (state_q != ST_LOAD_DATA);

  imem_arbiter_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_data  (load_byte),
    .byte_valid (pk_valid),
    .word       (packed_word),
    .word_done  (packed_done)
  );

  assign len_full    = {load_byte, len_q[7:0]};
  assign wc_last     = (wc_q + LEN_W'(1)) == len_q;
  assign wc_in_range = 32'(wc_q) < IMEM_WORDS;

  // The RAM read path is a plain passthrough; fetch_valid qualifies it.
  assign fetch_instr = mem_dout;
  // The packed word stays stable through the write cycle: a byte arriving
  // then only updates the register at the following edge.
  assign mem_din     = packed_word;

  always_comb begin
    state_d     = state_q;
    cpu_hold    = 1'b1;
    fetch_valid = 1'b0;
    mem_addr    = wc_q[IMEM_AW-1:0];
    mem_we      = 1'b0;
    load_done   = 1'b0;
    cpu_restart = 1'b0;
    case (state_q)
      ST_RUN: begin
        cpu_hold    = 1'b0;
        mem_addr    = fetch_addr;
        fetch_valid = fetch_pend_q;
        if (load_start) state_d = ST_LOAD_LEN;
      end
      ST_LOAD_LEN: begin
        if (load_byte_valid && len_hi_q)
          state_d = (len_full == '0) ? ST_DONE : ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        mem_we = word_pend_q && wc_in_range;
        if (word_pend_q && wc_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        load_done   = 1'b1;
        cpu_restart = 1'b1;
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      len_q        <= '0;
      wc_q         <= '0;
      len_hi_q     <= 1'b0;
      fetch_pend_q <= 1'b0;
      word_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pend_q <= fetch_req && (state_q == ST_RUN);
      // Word completed this cycle is written (or skipped) in the next one.
      word_pend_q  <= packed_done;
      if (state_q == ST_RUN && load_start) begin
        wc_q     <= '0;
        len_hi_q <= 1'b0;
      end
      if (state_q == ST_LOAD_LEN && load_byte_valid) begin
        if (len_hi_q) len_q[15:8] <= load_byte;
        else          len_q[7:0]  <= load_byte;
        len_hi_q <= !len_hi_q;
      end
      if (state_q == ST_LOAD_DATA && word_pend_q) wc_q <= wc_q + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - self-checking bench for imem_arbiter

module tb_imem_arbiter;

  localparam int TB_WORDS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [13:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        fetch_valid;
  logic        cpu_hold;
  logic        cpu_restart;
  logic        load_start;
  logic [7:0]  load_byte;
  logic        load_byte_valid;
  logic        load_done;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;

  always #5 clk = ~clk;

  imem_arbiter #(.IMEM_WORDS(TB_WORDS)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .fetch_instr     (fetch_instr),
    .fetch_valid     (fetch_valid),
    .cpu_hold        (cpu_hold),
    .cpu_restart     (cpu_restart),
    .load_start      (load_start),
    .load_byte       (load_byte),
    .load_byte_valid (load_byte_valid),
    .load_done       (load_done),
    .mem_addr        (mem_addr),
    .mem_din         (mem_din),
    .mem_we          (mem_we),
    .mem_dout        (mem_dout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Observed RAM writes and pulse counts
  logic [45:0] wr_log[$];
  int done_cnt = 0;
  int restart_cnt = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) wr_log.push_back({mem_addr, mem_din});
    if (load_done === 1'b1) done_cnt++;
    if (cpu_restart === 1'b1) restart_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected writes for a whole download image
  logic [7:0]  dl_bytes[$];
  logic [45:0] exp_wr[$];

  task automatic build_expected();
    int len;
    logic [31:0] word;
    exp_wr.delete();
    len = int'(dl_bytes[1]) * 256 + int'(dl_bytes[0]);
    for (int w = 0; w < len; w++) begin
      word = 32'd0;
      for (int b = 0; b < 4; b++) word = word | (32'(dl_bytes[2 + 4*w + b]) << (8*b));
      if (w < TB_WORDS) exp_wr.push_back({14'(w), word});
    end
  endtask

  task automatic download(input int gap_max, input int ls_at);
    int base_wr;
    int base_done;
    int base_rs;
    int waited;
    int gap;
    base_wr   = wr_log.size();
    base_done = done_cnt;
    base_rs   = restart_cnt;
    build_expected();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("hold_in_load", 64'(cpu_hold), 64'd1);
    check("fetch_valid_in_load", 64'(fetch_valid), 64'd0);
    for (int i = 0; i < dl_bytes.size(); i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) begin
        load_byte = 8'($urandom);
        tick();
      end
      load_byte       = dl_bytes[i];
      load_byte_valid = 1'b1;
      load_start      = (i == ls_at);
      tick();
      load_byte_valid = 1'b0;
      load_start      = 1'b0;
    end
    waited = 0;
    while (done_cnt == base_done && waited < 20) begin
      tick();
      waited++;
    end
    check("hold_after_done", 64'(cpu_hold), 64'd0);
    tick();
    tick();
    check("load_done_pulses", 64'(done_cnt - base_done), 64'd1);
    check("restart_pulses", 64'(restart_cnt - base_rs), 64'd1);
    check("write_count", 64'(wr_log.size() - base_wr), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && base_wr + i < wr_log.size(); i++)
      check("write_entry", 64'(wr_log[base_wr + i]), 64'(exp_wr[i]));
  endtask

  typedef struct {
    logic        rst;
    logic        req;
    logic [13:0] addr;
    logic [31:0] dout;
    logic        exp_fv;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base;
    int base_done;
    int base_rs;
    int len;

    vecs[0] = '{1'b0, 1'b1, 14'h0005, 32'h00500093, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 14'h0007, 32'h00500093, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 14'h3FFF, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 14'h0000, 32'h12345678, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 14'h1234, 32'h00000000, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 14'h2AAA, 32'hFFFFFFFF, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 14'h0001, 32'h11111111, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 14'h0002, 32'h22222222, 1'b0};

    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0;
    load_byte = '0; load_byte_valid = 1'b0; mem_dout = 32'hCAFE0001;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    check("rst_fetch_instr", 64'(fetch_instr), 64'hCAFE0001);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_cpu_restart", 64'(cpu_restart), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_din", 64'(mem_din), 64'd0);

    // Fetch path vectors
    for (int k = 0; k < 8; k++) begin
      tick();
      rst        = vecs[k].rst;
      fetch_req  = vecs[k].req;
      fetch_addr = vecs[k].addr;
      mem_dout   = vecs[k].dout;
      @(negedge clk);
      check("vec_fetch_valid", 64'(fetch_valid), 64'(vecs[k].exp_fv));
      check("vec_fetch_instr", 64'(fetch_instr), 64'(vecs[k].dout));
      check("vec_mem_addr", 64'(mem_addr), 64'(vecs[k].addr));
      check("vec_cpu_hold", 64'(cpu_hold), 64'd0);
      check("vec_mem_we", 64'(mem_we), 64'd0);
    end
    tick();
    rst = 1'b0;
    fetch_req = 1'b1;

    // Two-word download with known contents
    base = wr_log.size();
    dl_bytes = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    download(0, -1);
    if (wr_log.size() >= base + 2) begin
      check("known_word0", 64'(wr_log[base]), 64'({14'd0, 32'h00000013}));
      check("known_word1", 64'(wr_log[base + 1]), 64'({14'd1, 32'h00500093}));
    end else begin
      check("known_write_count", 64'(wr_log.size() - base), 64'd2);
    end

    // Zero-length download
    dl_bytes = '{8'h00, 8'h00};
    download(1, -1);

    // Three words back-to-back
    dl_bytes = '{8'h03, 8'h00};
    for (int i = 0; i < 12; i++) dl_bytes.push_back(8'($urandom));
    download(0, -1);

    // Reset after 6 of 10 bytes aborts the download
    base = wr_log.size(); base_done = done_cnt; base_rs = restart_cnt;
    dl_bytes = '{8'h02, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_byte = dl_bytes[i]; load_byte_valid = 1'b1; tick();
    end
    load_byte_valid = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort_hold", 64'(cpu_hold), 64'd0);
    for (int i = 6; i < 10; i++) begin
      load_byte = dl_bytes[i]; load_byte_valid = 1'b1; tick();
    end
    load_byte_valid = 1'b0;
    repeat (4) tick();
    check("abort_write_count", 64'(wr_log.size() - base), 64'd1);
    if (wr_log.size() > base)
      check("abort_first_word", 64'(wr_log[base]), 64'({14'd0, 32'hA4A3A2A1}));
    check("abort_no_done", 64'(done_cnt - base_done), 64'd0);
    check("abort_no_restart", 64'(restart_cnt - base_rs), 64'd0);
    dl_bytes = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    download(0, -1);

    // load_start during LOAD_DATA is ignored
    dl_bytes = '{8'h02, 8'h00};
    for (int i = 0; i < 8; i++) dl_bytes.push_back(8'($urandom));
    download(0, 5);

    // Randomized downloads, including lengths past TB_WORDS
    for (int it = 0; it < 12; it++) begin
      len = int'($urandom_range(12, 0));
      dl_bytes.delete();
      dl_bytes.push_back(8'(len));
      dl_bytes.push_back(8'(len >> 8));
      for (int i = 0; i < 4*len; i++) dl_bytes.push_back(8'($urandom));
      download(2, int'($urandom_range(4*len + 5, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
